// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: shared segment enum, timing presets and total helper for vga_timing_gen.
package vga_timing_pkg;

    typedef enum logic [1:0] {SEG_ACTIVE, SEG_FP, SEG_SYNC, SEG_BP} seg_e;

    typedef struct packed {
        logic [15:0] active;
        logic [15:0] fp;
        logic [15:0] sync;
        logic [15:0] bp;
    } axis_t;

    typedef struct packed {
        axis_t h;
        axis_t v;
        logic  hsync_pol;
        logic  vsync_pol;
    } timing_t;

    localparam timing_t VGA_640X480_60 = '{
        h: '{16'd640, 16'd16, 16'd96, 16'd48},
        v: '{16'd480, 16'd10, 16'd2, 16'd33},
        hsync_pol: 1'b0,
        vsync_pol: 1'b0
    };

    localparam timing_t SVGA_800X600_60 = '{
        h: '{16'd800, 16'd40, 16'd128, 16'd88},
        v: '{16'd600, 16'd1, 16'd4, 16'd23},
        hsync_pol: 1'b1,
        vsync_pol: 1'b1
    };

    function automatic int unsigned seg_total(input int unsigned active, input int unsigned fp,
                                              input int unsigned sync, input int unsigned bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_axis_decode.sv
// vga_axis_decode: classifies one raster axis count into active / sync windows.
module vga_axis_decode
    import vga_timing_pkg::*;
#(
    parameter int CNT_W  = 11,
    parameter int ACTIVE = 640,
    parameter int FP     = 16,
    parameter int SYNC   = 96
) (
    input  logic [CNT_W-1:0] i_cnt,
    output logic             o_active,
    output logic             o_sync
);

    // One extra bit so a boundary equal to 2^CNT_W still compares correctly.
    localparam logic [CNT_W:0] L_FP_S   = (CNT_W+1)'(ACTIVE);
    localparam logic [CNT_W:0] L_SYNC_S = (CNT_W+1)'(ACTIVE + FP);
    localparam logic [CNT_W:0] L_BP_S   = (CNT_W+1)'(ACTIVE + FP + SYNC);

    logic [CNT_W:0] w_cnt;
    seg_e           w_seg;

    assign w_cnt = {1'b0, i_cnt};

    always_comb begin
        w_seg    = (w_cnt < L_FP_S)   ? SEG_ACTIVE :
                   (w_cnt < L_SYNC_S) ? SEG_FP :
                   (w_cnt < L_BP_S)   ? SEG_SYNC : SEG_BP;
        o_active = (w_seg == SEG_ACTIVE);
        o_sync   = (w_seg == SEG_SYNC);
    end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA/DVI raster timing generator advancing on pix_en.
// Optional line-match strobe enabled by defining VGA_TIMING_LINE_MATCH_EN.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int CNT_W     = 11,
    parameter int H_ACTIVE  = int'(VGA_640X480_60.h.active),
    parameter int H_FP      = int'(VGA_640X480_60.h.fp),
    parameter int H_SYNC    = int'(VGA_640X480_60.h.sync),
    parameter int H_BP      = int'(VGA_640X480_60.h.bp),
    parameter int V_ACTIVE  = int'(VGA_640X480_60.v.active),
    parameter int V_FP      = int'(VGA_640X480_60.v.fp),
    parameter int V_SYNC    = int'(VGA_640X480_60.v.sync),
    parameter int V_BP      = int'(VGA_640X480_60.v.bp),
    parameter bit HSYNC_POL = VGA_640X480_60.hsync_pol,
    parameter bit VSYNC_POL = VGA_640X480_60.vsync_pol
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pix_en,
    input  logic [CNT_W-1:0] match_line,
    output logic             hsync,
    output logic             vsync,
    output logic             de,
    output logic [CNT_W-1:0] x,
    output logic [CNT_W-1:0] y,
    output logic             sol,
    output logic             sof,
    output logic             line_irq
);

    localparam int H_TOTAL = int'(seg_total(H_ACTIVE, H_FP, H_SYNC, H_BP));
    localparam int V_TOTAL = int'(seg_total(V_ACTIVE, V_FP, V_SYNC, V_BP));

    if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
        V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 || CNT_W < 1 ||
        longint'(H_TOTAL) > (longint'(1) << CNT_W) ||
        longint'(V_TOTAL) > (longint'(1) << CNT_W)) begin : g_param_err
        $error("vga_timing_gen: invalid timing parameters");
    end

    logic [CNT_W-1:0] r_hcnt;
    logic [CNT_W-1:0] r_vcnt;
    logic             w_h_act;
    logic             w_h_sync;
    logic             w_v_act;
    logic             w_v_sync;
    logic             w_h_last;
    logic             w_v_last;
    logic             w_de;
    logic             w_line_hit;

    vga_axis_decode #(
        .CNT_W (CNT_W),
        .ACTIVE(H_ACTIVE),
        .FP    (H_FP),
        .SYNC  (H_SYNC)
    ) u_h_decode (
        .i_cnt   (r_hcnt),
        .o_active(w_h_act),
        .o_sync  (w_h_sync)
    );

    vga_axis_decode #(
        .CNT_W (CNT_W),
        .ACTIVE(V_ACTIVE),
        .FP    (V_FP),
        .SYNC  (V_SYNC)
    ) u_v_decode (
        .i_cnt   (r_vcnt),
        .o_active(w_v_act),
        .o_sync  (w_v_sync)
    );

    assign w_h_last = (r_hcnt == CNT_W'(H_TOTAL - 1));
    assign w_v_last = (r_vcnt == CNT_W'(V_TOTAL - 1));
    assign w_de     = w_h_act && w_v_act;

`ifdef VGA_TIMING_LINE_MATCH_EN
    // Fires at the first hblank pixel; values >= V_TOTAL never equal r_vcnt.
    assign w_line_hit = (r_hcnt == CNT_W'(H_ACTIVE)) && (r_vcnt == match_line);
`else
    logic w_unused_match;
    assign w_unused_match = ^match_line;
    assign w_line_hit     = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hcnt   <= '0;
            r_vcnt   <= '0;
            hsync    <= !HSYNC_POL;
            vsync    <= !VSYNC_POL;
            de       <= 1'b0;
            x        <= '0;
            y        <= '0;
            sol      <= 1'b0;
            sof      <= 1'b0;
            line_irq <= 1'b0;
        end else begin
            // Strobes reload every clk so they are one clk wide even with sparse pix_en.
            sol      <= pix_en && (r_hcnt == '0) && w_v_act;
            sof      <= pix_en && (r_hcnt == '0) && (r_vcnt == '0);
            line_irq <= pix_en && w_line_hit;
            if (pix_en) begin
                r_hcnt <= w_h_last ? '0 : r_hcnt + 1'b1;
                r_vcnt <= !w_h_last ? r_vcnt : (w_v_last ? '0 : r_vcnt + 1'b1);
                hsync  <= w_h_sync ? HSYNC_POL : !HSYNC_POL;
                vsync  <= w_v_sync ? VSYNC_POL : !VSYNC_POL;
                de     <= w_de;
                x      <= w_de ? r_hcnt : '0;
                y      <= w_de ? r_vcnt : '0;
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: randomized self-checking bench on a tiny raster against a frame-index model.
module tb_vga_timing_gen;

    localparam int CW = 4;
    localparam int HA = 4, HF = 1, HS = 2, HB = 1;
    localparam int VA = 3, VF = 1, VS = 1, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FT = HT * VT;
`ifdef VGA_TIMING_LINE_MATCH_EN
    localparam bit LM = 1'b1;
`else
    localparam bit LM = 1'b0;
`endif
    // {hsync,vsync,de,x,y,sol,sof,line_irq}; polarities are 1 so reset is all zero
    localparam logic [13:0] RST_VEC   = 14'b0;
    localparam logic [13:0] FIRST_VEC = {1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 1'b1, 1'b1, 1'b0};

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          pix_en = 1'b0;
    logic [CW-1:0] match_line = '0;
    logic          hsync, vsync, de, sol, sof, line_irq;
    logic [CW-1:0] x, y;

    int          n_cmp = 0;
    int          n_err = 0;
    int          m_idx = 0;
    logic [13:0] e_vec = RST_VEC;

    always #5 clk = ~clk;

    vga_timing_gen #(
        .CNT_W(CW), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HSYNC_POL(1'b1), .VSYNC_POL(1'b1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .match_line(match_line),
        .hsync(hsync), .vsync(vsync), .de(de), .x(x), .y(y),
        .sol(sol), .sof(sof), .line_irq(line_irq)
    );

    function automatic logic [13:0] got_vec();
        return {hsync, vsync, de, x, y, sol, sof, line_irq};
    endfunction

    // Model: m_idx is the linear position inside the frame of the next sample.
    task automatic step(input logic en);
        int   hc, vc;
        logic d;
        pix_en = en;
        @(posedge clk);
        if (en) begin
            hc    = m_idx % HT;
            vc    = m_idx / HT;
            d     = (hc < HA) && (vc < VA);
            e_vec = {1'(hc >= HA + HF && hc < HA + HF + HS), 1'(vc >= VA + VF && vc < VA + VF + VS),
                     d, d ? 4'(hc) : 4'd0, d ? 4'(vc) : 4'd0,
                     1'(hc == 0 && vc < VA), 1'(m_idx == 0),
                     1'(LM && hc == HA && vc == int'(match_line))};
            m_idx = (m_idx + 1) % FT;
        end else begin
            e_vec[2:0] = 3'b000;
        end
        #1;
    endtask

    task automatic test_reset();
        #3;
        n_cmp++;
        if (got_vec() !== RST_VEC) begin
            n_err++;
            $display("FAIL reset_value: got %b expected %b", got_vec(), RST_VEC);
        end
        pix_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            n_cmp++;
            if (got_vec() !== RST_VEC) begin
                n_err++;
                $display("FAIL reset_hold %0d: got %b expected %b", i, got_vec(), RST_VEC);
            end
        end
        #2 rst_n = 1'b1;
        pix_en = 1'b0;
    endtask

    task automatic test_first_edge();
        step(1'b1);
        n_cmp++;
        if (got_vec() !== FIRST_VEC) begin
            n_err++;
            $display("FAIL first_edge: got %b expected %b", got_vec(), FIRST_VEC);
        end
    endtask

    task automatic test_continuous();
        int xseq[8] = '{0, 1, 2, 3, 0, 0, 0, 0};
        int sof_at[$];
        int k0 = -1;
        for (int i = 0; i < 2 * FT; i++) begin
            step(1'b1);
            n_cmp++;
            if (got_vec() !== e_vec) begin
                n_err++;
                $display("FAIL continuous %0d: got %b expected %b", i, got_vec(), e_vec);
            end
            if (sof === 1'b1) begin
                sof_at.push_back(i);
                if (k0 < 0) k0 = i;
            end
            if (k0 >= 0 && i - k0 < HT) begin
                n_cmp++;
                if (int'(x) !== xseq[i - k0] || hsync !== 1'((i - k0) == 5 || (i - k0) == 6)) begin
                    n_err++;
                    $display("FAIL line_shape idx %0d: got x=%0d hs=%b expected x=%0d", i - k0, x, hsync, xseq[i - k0]);
                end
            end
        end
        n_cmp++;
        if (sof_at.size() != 2 || sof_at[1] - sof_at[0] != FT) begin
            n_err++;
            $display("FAIL sof_period: got %0d strobes expected 2 spaced %0d", sof_at.size(), FT);
        end
    endtask

    task automatic test_alternating();
        int sof_clk[$];
        for (int i = 0; i < 4 * FT; i++) begin
            step(i[0] == 1'b0);
            n_cmp++;
            if (got_vec() !== e_vec) begin
                n_err++;
                $display("FAIL alternating %0d: got %b expected %b", i, got_vec(), e_vec);
            end
            if (sof === 1'b1) sof_clk.push_back(i);
        end
        n_cmp++;
        if (sof_clk.size() != 2 || sof_clk[1] - sof_clk[0] != 2 * FT) begin
            n_err++;
            $display("FAIL alt_frame_period: got %0d strobes expected 2 spaced %0d", sof_clk.size(), 2 * FT);
        end
    endtask

    task automatic test_random();
        for (int f = 0; f < 6; f++) begin
            match_line = CW'($urandom_range(0, VT + 1));
            for (int i = 0; i < FT; i++) begin
                step($urandom_range(0, 3) != 0);
                n_cmp++;
                if (got_vec() !== e_vec) begin
                    n_err++;
                    $display("FAIL random f%0d s%0d: got %b expected %b", f, i, got_vec(), e_vec);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        int n = $urandom_range(10, 40);
        for (int i = 0; i < n; i++) step(1'b1);
        #2 rst_n = 1'b0;
        #1;
        m_idx = 0;
        e_vec = RST_VEC;
        n_cmp++;
        if (got_vec() !== RST_VEC) begin
            n_err++;
            $display("FAIL async_reset after %0d: got %b expected %b", n, got_vec(), RST_VEC);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (got_vec() !== RST_VEC) begin
            n_err++;
            $display("FAIL async_reset_hold: got %b expected %b", got_vec(), RST_VEC);
        end
        #2 rst_n = 1'b1;
        step(1'b1);
        n_cmp++;
        if (got_vec() !== FIRST_VEC) begin
            n_err++;
            $display("FAIL restart: got %b expected %b", got_vec(), FIRST_VEC);
        end
    endtask

    task automatic test_line_match();
        int ml[3] = '{2, VT, 15};
        int hits;
        for (int t = 0; t < 3; t++) begin
            match_line = CW'(ml[t]);
            hits = 0;
            for (int i = 0; i < FT; i++) begin
                step(1'b1);
                n_cmp++;
                if (got_vec() !== e_vec) begin
                    n_err++;
                    $display("FAIL line_match ml=%0d s%0d: got %b expected %b", ml[t], i, got_vec(), e_vec);
                end
                hits += int'(line_irq === 1'b1);
            end
            n_cmp++;
            if (hits != ((LM && ml[t] < VT) ? 1 : 0)) begin
                n_err++;
                $display("FAIL line_irq_count ml=%0d: got %0d expected %0d", ml[t], hits, (LM && ml[t] < VT) ? 1 : 0);
            end
        end
    endtask

    initial begin
        test_reset();
        test_first_edge();
        test_continuous();
        test_alternating();
        test_random();
        test_async_reset();
        test_line_match();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
